// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the kgp_seq_alu multi-cycle ALU: op codes, FSM states, flag positions.
package kgp_alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b10000;
  localparam logic [4:0] OP_SUB = 5'b10001;
  localparam logic [4:0] OP_AND = 5'b10010;
  localparam logic [4:0] OP_OR  = 5'b10011;
  localparam logic [4:0] OP_XOR = 5'b10100;
  localparam logic [4:0] OP_NOT = 5'b10101;
  localparam logic [4:0] OP_SLL = 5'b11000;
  localparam logic [4:0] OP_SRL = 5'b11001;
  localparam logic [4:0] OP_SRA = 5'b11010;
  localparam logic [4:0] OP_MUL = 5'b11100;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_SIGN  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/kgp_alu_shift_step.sv
// One-bit shift of a value for SLL/SRL/SRA; carry_c is the bit shifted out.
module kgp_alu_shift_step
  import kgp_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] value_c,
  output logic             carry_c
);

  always_comb begin
    value_c = value;
    carry_c = 1'b0;
    case (op)
      OP_SLL: begin
        value_c = {value[WIDTH-2:0], 1'b0};
        carry_c = value[WIDTH-1];
      end
      OP_SRL: begin
        value_c = {1'b0, value[WIDTH-1:1]};
        carry_c = value[0];
      end
      OP_SRA: begin
        value_c = {value[WIDTH-1], value[WIDTH-1:1]};
        carry_c = value[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/kgp_seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides; iterative shifts, optional shift-add multiply.
// Build option: define KGP_ALU_MUL_EN to include the MUL op and its datapath.
module kgp_seq_alu
  import kgp_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             err
);

  // Counter must hold WIDTH for the multiply iteration count.
  localparam int unsigned CW = SHW + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, val_q;
  logic [4:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             accept_c;
  logic [WIDTH-1:0] step_value_c;
  logic             step_carry_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, err_c;
  logic [2:0]       flags_c;

  assign accept_c = in_valid & in_ready;

`ifdef KGP_ALU_MUL_EN
  // Shift-add: upper product half in hi_q, multiplier/lower half shifts through val_q.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH:0]   madd_c;
  assign madd_c = val_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
`endif

  kgp_alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .value   (val_q),
    .op      (op_q),
    .value_c (step_value_c),
    .carry_c (step_carry_c)
  );

  assign sum_c = (op_q == OP_SUB) ? ({1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1))
                                  : ({1'b0, a_q} + {1'b0, b_q});

  // Final result selection, evaluated in the last EXEC cycle.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOT: res_c = ~a_q;
      OP_SLL, OP_SRL, OP_SRA: begin
        res_c   = val_q;
        carry_c = carry_q;
      end
`ifdef KGP_ALU_MUL_EN
      OP_MUL: begin
        res_c   = val_q;
        carry_c = |hi_q;
      end
`endif
      default: err_c = 1'b1;
    endcase
    flags_c             = '0;
    flags_c[FLAG_CARRY] = carry_c;
    flags_c[FLAG_ZERO]  = (res_c == '0);
    flags_c[FLAG_SIGN]  = res_c[WIDTH-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = S_EXEC;
      S_EXEC:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      val_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      flags   <= '0;
      err     <= 1'b0;
`ifdef KGP_ALU_MUL_EN
      hi_q    <= '0;
`endif
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      val_q   <= a;
      carry_q <= 1'b0;
      cnt     <= op_is_shift(op) ? CW'(b[SHW-1:0]) : '0;
`ifdef KGP_ALU_MUL_EN
      hi_q    <= '0;
      if (op == OP_MUL) begin
        cnt   <= CW'(WIDTH);
        val_q <= b;
      end
`endif
    end else if (state == S_EXEC) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
`ifdef KGP_ALU_MUL_EN
        if (op_q == OP_MUL) begin
          hi_q  <= madd_c[WIDTH:1];
          val_q <= {madd_c[0], val_q[WIDTH-1:1]};
        end else begin
          val_q   <= step_value_c;
          carry_q <= step_carry_c;
        end
`else
        val_q   <= step_value_c;
        carry_q <= step_carry_c;
`endif
      end else begin
        result <= res_c;
        flags  <= flags_c;
        err    <= err_c;
      end
    end
  end

endmodule

// File: doc/kgp_seq_alu.md
Name: kgp_seq_alu

Overview:
Parametrised, multi-cycle successor to the KGPMini single-cycle ALU, with a valid/ready handshake on both sides.
- Logic and add/sub ops finish in one cycle.
- Shifts run iteratively, one bit per cycle.
- Optional multiply uses shift-add.
- Sits between the decode/register-read stage and writeback, so the core can stall on long ops instead of adding a barrel shifter and multiplier array.

Parameters:
WIDTH, 32, operand/result width (>=4)
SHW, $clog2(WIDTH), width of shift-amount field taken from B[SHW-1:0]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block idle, can accept
a  in  WIDTH  operand A
b  in  WIDTH  operand B / shift amount
op  in  5  operation code (kgp_alu_pkg)
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flags  out  3  {sign, zero, carry}: flags[0]=carry, flags[1]=zero, flags[2]=sign
err  out  1  illegal op code (valid with result)

Behaviour:
- Single clock, rst synchronous active-high. On reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, err=0.
- rst mid-operation aborts the op with no output.
- Accept on in_valid & in_ready. Operands and op are latched; in_ready drops the following cycle.
- FSM IDLE -> EXEC -> DONE -> IDLE:
  - IDLE: in_ready=1; on accept go to EXEC.
  - EXEC, single-cycle ops: compute and register, go to DONE. out_valid rises 1 cycle after accept.
  - EXEC, shifts: a counter loads amt=b[SHW-1:0]. Each cycle shift 1 bit and decrement. Go to DONE when the counter reaches 0.
    - Latency = amt+1 cycles.
    - amt=0 gives latency 1, result=a, carry=0.
  - EXEC, MUL: WIDTH iterations, latency WIDTH+1.
  - DONE: out_valid=1, result/flags/err stable. On out_ready go to IDLE. Backpressure holds DONE indefinitely.
- No new accept while busy. There is no pass-through from DONE to EXEC in the same cycle.
- Ops (5-bit, package constants):
  - ADD 10000: a+b; carry = bit WIDTH of the sum.
  - SUB 10001: a+~b+1; carry = carry-out (1 = no borrow).
  - AND 10010, OR 10011, XOR 10100, NOT 10101 (~a): carry=0.
  - SLL 11000, SRL 11001, SRA 11010 (sign-fill): carry = last bit shifted out.
  - MUL 11100: low WIDTH bits of a*b, unsigned; carry = 1 if the high half is nonzero.
- zero = (result==0); sign = result[WIDTH-1].
- ADD/SUB wrap modulo 2^WIDTH.
- Illegal op: single-cycle, result=0, flags=3'b010, err=1.

Optional Feature:
KGP_ALU_MUL_EN
- Defined: the MUL op, its accumulator and the WIDTH-cycle iteration are built.
- Undefined: MUL is treated as an illegal op (result=0, flags=010, err=1) and the multiplier datapath is omitted.

Decomposition:
- kgp_alu_pkg: op-code localparams, state encoding, flag bit indices.
- One sub-module, kgp_alu_shift_step: combinational one-bit shift of {value, carry} for SLL/SRL/SRA. It is reused per iteration by the EXEC shift path.

Test Plan:
- ADD a=512 b=512 -> out_valid after 1 cycle, result=1024, flags=000; then a=150 b=150 -> 300.
- SUB a=150 b=150 -> result=0, flags zero=1, carry=1; a=10 b=1243 -> result=2^32-1233, sign=1, carry=0.
- SRA a=0x80000000 b=4 -> out_valid 5 cycles after accept, result=0xF8000000, sign=1, carry=0; SLL with b=0 -> 1-cycle latency, result=a.
- Backpressure: hold out_ready=0 for 10 cycles after an ADD -> result/flags stable, in_ready=0, second in_valid ignored until out_ready.
- rst asserted mid-SLL (amt=20, cycle 7) -> next cycle in_ready=1, out_valid=0, result=0; a new ADD then completes normally.
- MUL a=1243 b=10 with KGP_ALU_MUL_EN -> result=12430 after 33 cycles, carry=0; without the macro -> err=1, result=0, flags=010.
